// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller.
// Holds the stall-vector encodings, the eret code, FSM encodings and the request priority helper.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_ERET = 32'h0000000e;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_STALLED = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    typedef struct packed {
        logic mem;
        logic ex;
        logic id;
    } stall_req_t;

    // Deeper stage wins: a MEM hold must also freeze everything upstream of it.
    function automatic logic [5:0] stall_encode(input stall_req_t r);
        if (r.mem)     return STALL_MEM;
        else if (r.ex) return STALL_EX;
        else if (r.id) return STALL_ID;
        return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline stages and the sequencing controller.
// master = pipeline side (raises requests), slave = controller.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
    logic             stallreq_id;
    logic             stallreq_ex;
    logic             stallreq_mem;
    logic [31:0]      excepttype_i;
    logic [31:0]      cp0_epc_i;
    logic             cnt_clr;
    logic [5:0]       stall;
    logic             flush;
    logic [31:0]      new_pc;
    logic             stall_timeout;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, cnt_clr,
        input  stall, flush, new_pc, stall_timeout, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i, cnt_clr,
        output stall, flush, new_pc, stall_timeout, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Clear has priority over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst)                        r_cnt <= '0;
        else if (i_clr)                 r_cnt <= '0;
        else if (i_inc && r_cnt != '1)  r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: same-cycle stall/flush generation, post-flush
// recovery window, stall watchdog and stall-cycle performance counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          FLUSH_BUBBLES = 2,
    parameter int          STALL_TIMEOUT = 1024,
    parameter int          CNT_W         = 32,
    parameter logic [31:0] EXC_VECTOR    = 32'h00000020
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int          WD_W         = 16;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT - 1);
    localparam logic [2:0]  RECOVER_INIT = 3'(FLUSH_BUBBLES - 1);

    logic [1:0]       r_state;
    logic [2:0]       r_recover_cnt;
    logic             r_stall_timeout;
    stall_req_t       w_req;
    logic             w_exc_take;
    logic [5:0]       w_stall;
    logic             w_flush;
    logic [31:0]      w_new_pc;
    logic [WD_W-1:0]  w_wd_cnt;
    logic [CNT_W-1:0] w_stall_cycles;

    assign w_req = {bus.stallreq_mem, bus.stallreq_ex, bus.stallreq_id};

    // Purely combinational: stages latch the hold in the same cycle it is raised.
    always_comb begin
        w_stall    = STALL_NONE;
        w_flush    = 1'b0;
        w_new_pc   = '0;
        w_exc_take = !rst && (bus.excepttype_i != '0) && (r_state != ST_RECOVER);
        if (!rst) begin
            if (w_exc_take) begin
                w_flush  = 1'b1;
                w_new_pc = (bus.excepttype_i == EXC_ERET) ? bus.cp0_epc_i : EXC_VECTOR;
            end else begin
                w_stall = stall_encode(w_req);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_recover_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_STALLED: begin
                    if (w_exc_take) begin
                        r_state       <= ST_RECOVER;
                        r_recover_cnt <= RECOVER_INIT;
                    end else begin
                        r_state <= w_stall[0] ? ST_STALLED : ST_RUN;
                    end
                end
                ST_RECOVER: begin
                    // Exceptions stay masked through the cycle in which the count hits zero.
                    if (r_recover_cnt == '0) r_state       <= w_stall[0] ? ST_STALLED : ST_RUN;
                    else                     r_recover_cnt <= r_recover_cnt - 3'd1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    sat_counter #(.W(WD_W)) u_wd_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall[0]),
        .i_clr (!w_stall[0]),
        .o_cnt (w_wd_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst)                                  r_stall_timeout <= 1'b0;
        else if (w_stall[0] && w_wd_cnt >= WD_LIMIT) r_stall_timeout <= 1'b1;
    end

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall[0]),
        .i_clr (bus.cnt_clr),
        .o_cnt (w_stall_cycles)
    );

    assign bus.stall         = w_stall;
    assign bus.flush         = w_flush;
    assign bus.new_pc        = w_new_pc;
    assign bus.stall_timeout = r_stall_timeout;
    assign bus.stall_cycles  = w_stall_cycles;
endmodule
